// File: rtl/instr_pkg.sv
// Shared MIPS encodings and decoded instruction codes for the decode stage.
// Codes 0..11 are the base ISA; 12..22 exist only when the extended ISA is enabled.
package instr_pkg;

    localparam int unsigned CODE_W_DEF = 6;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Funct field (instr[5:0]) under OP_RTYPE
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [5:0] {
        C_NOP  = 6'd0,
        C_ADDU = 6'd1,
        C_SUBU = 6'd2,
        C_JR   = 6'd3,
        C_SLL  = 6'd4,
        C_ORI  = 6'd5,
        C_LW   = 6'd6,
        C_SW   = 6'd7,
        C_BEQ  = 6'd8,
        C_LUI  = 6'd9,
        C_JAL  = 6'd10,
        C_J    = 6'd11,
        C_ADD  = 6'd12,
        C_SUB  = 6'd13,
        C_AND  = 6'd14,
        C_OR   = 6'd15,
        C_SLT  = 6'd16,
        C_ADDI = 6'd17,
        C_ANDI = 6'd18,
        C_BNE  = 6'd19,
        C_LB   = 6'd20,
        C_SB   = 6'd21,
        C_JALR = 6'd22
    } instr_code_e;

endpackage

// File: rtl/instr_decode_comb.sv
// Combinational instruction word -> {code, illegal, extended immediate}.
// Unknown encodings, and extended encodings when EXT_ISA=0, yield an all-ones code.
module instr_decode_comb
    import instr_pkg::*;
#(
    parameter int unsigned EXT_ISA = 1,
    parameter int unsigned CODE_W  = CODE_W_DEF
) (
    input  logic [31:0]       instr,
    output logic [CODE_W-1:0] code,
    output logic              illegal,
    output logic [31:0]       imm
);

    logic [5:0]  op;
    logic [5:0]  fn;
    logic        hit;
    instr_code_e c;

    assign op = instr[31:26];
    assign fn = instr[5:0];

    always_comb begin
        c   = C_NOP;
        hit = 1'b1;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    // the all-zero word is the canonical NOP, not "sll $0,$0,0"
                    FN_SLL:  c = (instr == '0) ? C_NOP : C_SLL;
                    FN_ADDU: c = C_ADDU;
                    FN_SUBU: c = C_SUBU;
                    FN_JR:   c = C_JR;
                    FN_ADD:  c = C_ADD;
                    FN_SUB:  c = C_SUB;
                    FN_AND:  c = C_AND;
                    FN_OR:   c = C_OR;
                    FN_SLT:  c = C_SLT;
                    FN_JALR: c = C_JALR;
                    default: hit = 1'b0;
                endcase
            end
            OP_ORI:  c = C_ORI;
            OP_LW:   c = C_LW;
            OP_SW:   c = C_SW;
            OP_BEQ:  c = C_BEQ;
            OP_LUI:  c = C_LUI;
            OP_JAL:  c = C_JAL;
            OP_J:    c = C_J;
            OP_ADDI: c = C_ADDI;
            OP_ANDI: c = C_ANDI;
            OP_BNE:  c = C_BNE;
            OP_LB:   c = C_LB;
            OP_SB:   c = C_SB;
            default: hit = 1'b0;
        endcase

        illegal = !hit || ((c >= C_ADD) && (EXT_ISA == 0));
        code    = illegal ? '1 : CODE_W'(c);

        imm = {{16{instr[15]}}, instr[15:0]};
        if (!illegal) begin
            case (c)
                C_ORI, C_ANDI: imm = {16'h0000, instr[15:0]};
                C_LUI:         imm = {instr[15:0], 16'h0000};
                C_J, C_JAL:    imm = {6'b000000, instr[25:0]};
                default:       ;
            endcase
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage between IF/ID and ID/EX: valid/ready handshake,
// flush and a saturating count of accepted illegal instructions.
module instr_decode_stage
    import instr_pkg::*;
#(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned CODE_W  = CODE_W_DEF,
    parameter int unsigned EXT_ISA = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [31:0]       out_imm,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_illegal,
    input  logic              flush,
    output logic [CNT_W-1:0]  illegal_cnt
);

    logic [CODE_W-1:0] dec_code;
    logic              dec_illegal;
    logic [31:0]       dec_imm;
    logic              xfer;

    instr_decode_comb #(
        .EXT_ISA (EXT_ISA),
        .CODE_W  (CODE_W)
    ) u_dec (
        .instr   (in_instr),
        .code    (dec_code),
        .illegal (dec_illegal),
        .imm     (dec_imm)
    );

    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_code    <= '0;
            out_rs      <= '0;
            out_rt      <= '0;
            out_rd      <= '0;
            out_shamt   <= '0;
            out_imm     <= '0;
            out_pc      <= '0;
            out_illegal <= 1'b0;
            illegal_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (xfer) begin
            // a transfer also covers the consume-and-refill case, so no bubble
            out_valid   <= 1'b1;
            out_code    <= dec_code;
            out_rs      <= in_instr[25:21];
            out_rt      <= in_instr[20:16];
            out_rd      <= in_instr[15:11];
            out_shamt   <= in_instr[10:6];
            out_imm     <= dec_imm;
            out_pc      <= in_pc;
            out_illegal <= dec_illegal;
            if (dec_illegal && (illegal_cnt != '1)) begin
                illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: scoreboard on the default instance,
// plus EXT_ISA=0 and CNT_W=2 instances fed from the same stimulus.
module tb_instr_decode_stage;
    import instr_pkg::*;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready, flush;
    logic [31:0] in_instr, in_pc;

    logic        m_in_ready, m_valid, m_illegal;
    logic [5:0]  m_code;
    logic [4:0]  m_rs, m_rt, m_rd, m_shamt;
    logic [31:0] m_imm, m_pc;
    logic [15:0] m_cnt;

    logic        b_in_ready, b_valid, b_illegal;
    logic [5:0]  b_code;
    logic [4:0]  b_rs, b_rt, b_rd, b_shamt;
    logic [31:0] b_imm, b_pc;
    logic [15:0] b_cnt;

    logic        s_in_ready, s_valid, s_illegal;
    logic [5:0]  s_code;
    logic [4:0]  s_rs, s_rt, s_rd, s_shamt;
    logic [31:0] s_imm, s_pc;
    logic [1:0]  s_cnt;

    always #5 clk = ~clk;

    instr_decode_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_valid), .out_ready(out_ready),
        .out_code(m_code), .out_rs(m_rs), .out_rt(m_rt), .out_rd(m_rd),
        .out_shamt(m_shamt), .out_imm(m_imm), .out_pc(m_pc), .out_illegal(m_illegal),
        .flush(flush), .illegal_cnt(m_cnt)
    );

    instr_decode_stage #(.EXT_ISA(0)) dut_base (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_valid), .out_ready(out_ready),
        .out_code(b_code), .out_rs(b_rs), .out_rt(b_rt), .out_rd(b_rd),
        .out_shamt(b_shamt), .out_imm(b_imm), .out_pc(b_pc), .out_illegal(b_illegal),
        .flush(flush), .illegal_cnt(b_cnt)
    );

    instr_decode_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(s_valid), .out_ready(out_ready),
        .out_code(s_code), .out_rs(s_rs), .out_rt(s_rt), .out_rd(s_rd),
        .out_shamt(s_shamt), .out_imm(s_imm), .out_pc(s_pc), .out_illegal(s_illegal),
        .flush(flush), .illegal_cnt(s_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  code;
        logic [31:0] imm;
        logic        illegal;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          exp_cnt  = 0;
    logic [31:0] pc_ctr   = 32'h0000_1000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard sink: every cycle with out_valid && out_ready consumes one result.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && m_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_code",    {26'b0, m_code},  {26'b0, e.code});
                chk("sb_imm",     m_imm,            e.imm);
                chk("sb_illegal", {31'b0, m_illegal}, {31'b0, e.illegal});
                chk("sb_rs",      {27'b0, m_rs},    {27'b0, e.instr[25:21]});
                chk("sb_rt",      {27'b0, m_rt},    {27'b0, e.instr[20:16]});
                chk("sb_rd",      {27'b0, m_rd},    {27'b0, e.instr[15:11]});
                chk("sb_shamt",   {27'b0, m_shamt}, {27'b0, e.instr[10:6]});
                chk("sb_pc",      m_pc,             e.pc);
            end
        end
    end

    // One cycle of stimulus; expectation is queued when the handshake accepts it.
    task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl,
                        input logic [5:0] code, input logic [31:0] imm, input logic ill);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc_ctr;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        if (v && m_in_ready && !fl) begin
            sb.push_back('{ins, pc_ctr, code, imm, ill});
            if (ill) exp_cnt++;
        end
        @(posedge clk);
        #1;
        pc_ctr   = pc_ctr + 32'd4;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b1; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",    {31'b0, m_valid},   32'd0);
        chk("rst_code",     {26'b0, m_code},    32'd0);
        chk("rst_imm",      m_imm,              32'd0);
        chk("rst_rs",       {27'b0, m_rs},      32'd0);
        chk("rst_pc",       m_pc,               32'd0);
        chk("rst_illegal",  {31'b0, m_illegal}, 32'd0);
        chk("rst_cnt",      {16'b0, m_cnt},     32'd0);
        chk("rst_in_ready", {31'b0, m_in_ready}, 32'd1);
        reset = 1'b0;

        // ori: zero-extended immediate
        step(1, 32'h34A5_FFFF, 1, 0, 6'd5, 32'h0000_FFFF, 0);
        chk("ori_valid", {31'b0, m_valid}, 32'd1);

        // addi: extended opcode, illegal only on the base-ISA instance
        step(1, 32'h2085_FFFC, 1, 0, 6'd17, 32'hFFFF_FFFC, 0);
        chk("base_addi_code",    {26'b0, b_code},    32'd63);
        chk("base_addi_illegal", {31'b0, b_illegal}, 32'd1);
        chk("base_addi_cnt",     {16'b0, b_cnt},     32'd1);
        chk("main_addi_cnt",     {16'b0, m_cnt},     32'd0);

        // backpressure: lw held for 3 cycles while sw waits
        step(1, 32'h8C43_0008, 1, 0, 6'd6, 32'd8, 0);
        for (int unsigned i = 0; i < 3; i++) begin
            step(1, 32'hAC43_0004, 0, 0, 6'd7, 32'd4, 0);
            chk("bp_in_ready", {31'b0, m_in_ready}, 32'd0);
            chk("bp_valid",    {31'b0, m_valid},    32'd1);
            chk("bp_code",     {26'b0, m_code},     32'd6);
            chk("bp_imm",      m_imm,               32'd8);
        end
        step(1, 32'hAC43_0004, 1, 0, 6'd7, 32'd4, 0);
        chk("nobubble_valid", {31'b0, m_valid}, 32'd1);
        chk("nobubble_code",  {26'b0, m_code},  32'd7);
        step(0, 32'h0, 1, 0, 6'd0, 32'd0, 0);
        chk("idle_valid", {31'b0, m_valid}, 32'd0);

        // flush with an incoming illegal word: dropped and not counted
        step(1, 32'hFC00_0000, 1, 1, 6'd63, 32'd0, 1);
        chk("flush_valid",    {31'b0, m_valid}, 32'd0);
        chk("flush_cnt",      {16'b0, m_cnt},   32'd0);
        chk("flush_base_cnt", {16'b0, b_cnt},   32'd1);

        step(1, 32'h0000_0000, 1, 0, 6'd0,  32'd0,          0); // NOP
        step(1, 32'h000A_5080, 1, 0, 6'd4,  32'h0000_5080,  0); // sll
        step(1, 32'h3C01_1234, 1, 0, 6'd9,  32'h1234_0000,  0); // lui
        step(1, 32'h0BFF_FFFF, 1, 0, 6'd11, 32'h03FF_FFFF,  0); // j
        step(1, 32'h1000_FFFF, 1, 0, 6'd8,  32'hFFFF_FFFF,  0); // beq
        step(1, 32'h3000_8000, 1, 0, 6'd18, 32'h0000_8000,  0); // andi
        step(1, 32'h0000_0001, 1, 0, 6'd63, 32'h0000_0001,  1); // bad funct
        chk("badfn_cnt",      {16'b0, m_cnt}, 32'd1);
        chk("badfn_base_cnt", {16'b0, b_cnt}, 32'd3);
        chk("badfn_sat_cnt",  {30'b0, s_cnt}, 32'd1);

        // saturation on the 2-bit counter
        for (int unsigned k = 1; k <= 5; k++) begin
            step(1, 32'hFC00_0000, 1, 0, 6'd63, 32'd0, 1);
            chk("sat_cnt",  {30'b0, s_cnt}, (k + 1 > 3) ? 32'd3 : 32'(k + 1));
            chk("base_cnt", {16'b0, b_cnt}, 32'(3 + k));
            chk("main_cnt", {16'b0, m_cnt}, 32'(exp_cnt));
        end

        // reset while a result is held
        step(1, 32'h34A5_FFFF, 1, 0, 6'd5, 32'h0000_FFFF, 0);
        out_ready = 1'b0;
        chk("pre_reset_valid", {31'b0, m_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        exp_cnt = 0;
        chk("midrst_valid",    {31'b0, m_valid}, 32'd0);
        chk("midrst_cnt",      {16'b0, m_cnt},   32'd0);
        chk("midrst_base_cnt", {16'b0, b_cnt},   32'd0);
        chk("midrst_sat_cnt",  {30'b0, s_cnt},   32'd0);
        reset = 1'b0;

        step(1, 32'h8C43_0008, 1, 0, 6'd6, 32'd8, 0);
        step(0, 32'h0, 1, 0, 6'd0, 32'd0, 0);
        step(0, 32'h0, 1, 0, 6'd0, 32'd0, 0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
